// File: rtl/uparc_idecode_pkg.sv
// Shared widths, opcode/funct encodings, ALU op codes and the ALU command
// payload for the Ultiparc instruction decode stage.
package uparc_idecode_pkg;

  localparam int unsigned UPARC_REG_WIDTH   = 32;
  localparam int unsigned UPARC_ALUOP_WIDTH = 4;
  localparam int unsigned UPARC_RADDR_WIDTH = 5;

  // ALU operations understood by the execute stage
  localparam logic [UPARC_ALUOP_WIDTH-1:0] UPARC_ALUOP_ADD  = 4'd0;
  localparam logic [UPARC_ALUOP_WIDTH-1:0] UPARC_ALUOP_SUB  = 4'd1;
  localparam logic [UPARC_ALUOP_WIDTH-1:0] UPARC_ALUOP_AND  = 4'd2;
  localparam logic [UPARC_ALUOP_WIDTH-1:0] UPARC_ALUOP_OR   = 4'd3;
  localparam logic [UPARC_ALUOP_WIDTH-1:0] UPARC_ALUOP_XOR  = 4'd4;
  localparam logic [UPARC_ALUOP_WIDTH-1:0] UPARC_ALUOP_NOR  = 4'd5;
  localparam logic [UPARC_ALUOP_WIDTH-1:0] UPARC_ALUOP_SLT  = 4'd6;
  localparam logic [UPARC_ALUOP_WIDTH-1:0] UPARC_ALUOP_SLTU = 4'd7;
  localparam logic [UPARC_ALUOP_WIDTH-1:0] UPARC_ALUOP_SLL  = 4'd8;
  localparam logic [UPARC_ALUOP_WIDTH-1:0] UPARC_ALUOP_SRL  = 4'd9;
  localparam logic [UPARC_ALUOP_WIDTH-1:0] UPARC_ALUOP_SRA  = 4'd10;

  // Primary opcodes
  localparam logic [5:0] UPARC_OPC_SPECIAL = 6'h00;
  localparam logic [5:0] UPARC_OPC_ADDI    = 6'h08;
  localparam logic [5:0] UPARC_OPC_ADDIU   = 6'h09;
  localparam logic [5:0] UPARC_OPC_SLTI    = 6'h0A;
  localparam logic [5:0] UPARC_OPC_SLTIU   = 6'h0B;
  localparam logic [5:0] UPARC_OPC_ANDI    = 6'h0C;
  localparam logic [5:0] UPARC_OPC_ORI     = 6'h0D;
  localparam logic [5:0] UPARC_OPC_XORI    = 6'h0E;
  localparam logic [5:0] UPARC_OPC_LUI     = 6'h0F;

  // SPECIAL function codes
  localparam logic [5:0] UPARC_FUNCT_SLL  = 6'h00;
  localparam logic [5:0] UPARC_FUNCT_SRL  = 6'h02;
  localparam logic [5:0] UPARC_FUNCT_SRA  = 6'h03;
  localparam logic [5:0] UPARC_FUNCT_SLLV = 6'h04;
  localparam logic [5:0] UPARC_FUNCT_SRLV = 6'h06;
  localparam logic [5:0] UPARC_FUNCT_SRAV = 6'h07;
  localparam logic [5:0] UPARC_FUNCT_ADD  = 6'h20;
  localparam logic [5:0] UPARC_FUNCT_ADDU = 6'h21;
  localparam logic [5:0] UPARC_FUNCT_SUB  = 6'h22;
  localparam logic [5:0] UPARC_FUNCT_SUBU = 6'h23;
  localparam logic [5:0] UPARC_FUNCT_AND  = 6'h24;
  localparam logic [5:0] UPARC_FUNCT_OR   = 6'h25;
  localparam logic [5:0] UPARC_FUNCT_XOR  = 6'h26;
  localparam logic [5:0] UPARC_FUNCT_NOR  = 6'h27;
  localparam logic [5:0] UPARC_FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] UPARC_FUNCT_SLTU = 6'h2B;

  // Operand source selects produced by the decoder
  typedef enum logic [1:0] {A_SEL_ZERO, A_SEL_RS, A_SEL_RT, A_SEL_IMM} a_sel_e;
  typedef enum logic [1:0] {B_SEL_ZERO, B_SEL_RS, B_SEL_RT, B_SEL_IMM} b_sel_e;

  // Registered ALU command handed to execute
  typedef struct packed {
    logic [UPARC_ALUOP_WIDTH-1:0] alu_op;
    logic [UPARC_REG_WIDTH-1:0]   a;
    logic [UPARC_REG_WIDTH-1:0]   b;
    logic [UPARC_RADDR_WIDTH-1:0] rd;
    logic                         wr_en;
    logic                         ovf_trap;
    logic                         rsvd;
  } alu_cmd_t;

endpackage

// File: rtl/uparc_idecode_if.sv
// Decode-stage boundary: fetch handshake, register file read port,
// forwarding input, flush and the ALU command output handshake.
interface uparc_idecode_if;
  import uparc_idecode_pkg::*;

  logic                         i_valid;
  logic                         i_ready;
  logic [31:0]                  i_instr;
  logic [UPARC_RADDR_WIDTH-1:0] rf_raddr_a;
  logic [UPARC_RADDR_WIDTH-1:0] rf_raddr_b;
  logic [UPARC_REG_WIDTH-1:0]   rf_rdata_a;
  logic [UPARC_REG_WIDTH-1:0]   rf_rdata_b;
  logic                         fwd_valid;
  logic [UPARC_RADDR_WIDTH-1:0] fwd_reg;
  logic [UPARC_REG_WIDTH-1:0]   fwd_data;
  logic                         flush;
  logic                         o_valid;
  logic                         o_ready;
  logic [UPARC_ALUOP_WIDTH-1:0] o_alu_op;
  logic [UPARC_REG_WIDTH-1:0]   o_a;
  logic [UPARC_REG_WIDTH-1:0]   o_b;
  logic [UPARC_RADDR_WIDTH-1:0] o_rd;
  logic                         o_wr_en;
  logic                         o_ovf_trap;
  logic                         o_rsvd;

  // Environment side: fetch, register file, execute
  modport master (
    output i_valid, i_instr, rf_rdata_a, rf_rdata_b,
           fwd_valid, fwd_reg, fwd_data, flush, o_ready,
    input  i_ready, rf_raddr_a, rf_raddr_b, o_valid, o_alu_op,
           o_a, o_b, o_rd, o_wr_en, o_ovf_trap, o_rsvd
  );

  // Decode stage side
  modport slave (
    input  i_valid, i_instr, rf_rdata_a, rf_rdata_b,
           fwd_valid, fwd_reg, fwd_data, flush, o_ready,
    output i_ready, rf_raddr_a, rf_raddr_b, o_valid, o_alu_op,
           o_a, o_b, o_rd, o_wr_en, o_ovf_trap, o_rsvd
  );

endinterface

// File: rtl/uparc_idec_logic.sv
// Purely combinational MIPS instruction decoder: ALU op, operand selects,
// extended immediate, destination register and write/trap/reserved flags.
module uparc_idec_logic
  import uparc_idecode_pkg::*;
(
  input  logic [31:0]                  instr,
  output logic [UPARC_RADDR_WIDTH-1:0] rs,
  output logic [UPARC_RADDR_WIDTH-1:0] rt,
  output logic [UPARC_ALUOP_WIDTH-1:0] alu_op,
  output a_sel_e                       a_sel,
  output b_sel_e                       b_sel,
  output logic [UPARC_REG_WIDTH-1:0]   imm,
  output logic [UPARC_RADDR_WIDTH-1:0] rd,
  output logic                         wr_en,
  output logic                         ovf_trap,
  output logic                         rsvd
);

  logic [5:0]                   opcode;
  logic [5:0]                   funct;
  logic [UPARC_REG_WIDTH-1:0]   simm;
  logic [UPARC_REG_WIDTH-1:0]   zimm;
  logic [UPARC_REG_WIDTH-1:0]   shamt;
  logic [UPARC_RADDR_WIDTH-1:0] dst;
  logic                         supported;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign simm   = {{16{instr[15]}}, instr[15:0]};
  assign zimm   = 32'(instr[15:0]);
  assign shamt  = 32'(instr[10:6]);

  // Opcode/funct decode; unsupported encodings keep the ADD/zero defaults
  always_comb begin
    alu_op    = UPARC_ALUOP_ADD;
    a_sel     = A_SEL_ZERO;
    b_sel     = B_SEL_ZERO;
    imm       = '0;
    dst       = '0;
    ovf_trap  = 1'b0;
    supported = 1'b0;
    case (opcode)
      UPARC_OPC_SPECIAL: begin
        dst       = instr[15:11];
        supported = 1'b1;
        a_sel     = A_SEL_RS;
        b_sel     = B_SEL_RT;
        case (funct)
          UPARC_FUNCT_ADD:  begin alu_op = UPARC_ALUOP_ADD; ovf_trap = 1'b1; end
          UPARC_FUNCT_ADDU: alu_op = UPARC_ALUOP_ADD;
          UPARC_FUNCT_SUB:  begin alu_op = UPARC_ALUOP_SUB; ovf_trap = 1'b1; end
          UPARC_FUNCT_SUBU: alu_op = UPARC_ALUOP_SUB;
          UPARC_FUNCT_AND:  alu_op = UPARC_ALUOP_AND;
          UPARC_FUNCT_OR:   alu_op = UPARC_ALUOP_OR;
          UPARC_FUNCT_XOR:  alu_op = UPARC_ALUOP_XOR;
          UPARC_FUNCT_NOR:  alu_op = UPARC_ALUOP_NOR;
          UPARC_FUNCT_SLT:  alu_op = UPARC_ALUOP_SLT;
          UPARC_FUNCT_SLTU: alu_op = UPARC_ALUOP_SLTU;
          UPARC_FUNCT_SLL, UPARC_FUNCT_SRL, UPARC_FUNCT_SRA: begin
            alu_op = (funct == UPARC_FUNCT_SLL) ? UPARC_ALUOP_SLL :
                     (funct == UPARC_FUNCT_SRL) ? UPARC_ALUOP_SRL : UPARC_ALUOP_SRA;
            a_sel  = A_SEL_RT;
            b_sel  = B_SEL_IMM;
            imm    = shamt;
          end
          UPARC_FUNCT_SLLV, UPARC_FUNCT_SRLV, UPARC_FUNCT_SRAV: begin
            alu_op = (funct == UPARC_FUNCT_SLLV) ? UPARC_ALUOP_SLL :
                     (funct == UPARC_FUNCT_SRLV) ? UPARC_ALUOP_SRL : UPARC_ALUOP_SRA;
            a_sel  = A_SEL_RT;
            b_sel  = B_SEL_RS;
          end
          default: begin
            supported = 1'b0;
            a_sel     = A_SEL_ZERO;
            b_sel     = B_SEL_ZERO;
          end
        endcase
      end
      UPARC_OPC_ADDI, UPARC_OPC_ADDIU, UPARC_OPC_SLTI, UPARC_OPC_SLTIU: begin
        dst       = rt;
        supported = 1'b1;
        a_sel     = A_SEL_RS;
        b_sel     = B_SEL_IMM;
        imm       = simm;
        ovf_trap  = (opcode == UPARC_OPC_ADDI);
        alu_op    = (opcode == UPARC_OPC_SLTI)  ? UPARC_ALUOP_SLT  :
                    (opcode == UPARC_OPC_SLTIU) ? UPARC_ALUOP_SLTU : UPARC_ALUOP_ADD;
      end
      UPARC_OPC_ANDI, UPARC_OPC_ORI, UPARC_OPC_XORI: begin
        dst       = rt;
        supported = 1'b1;
        a_sel     = A_SEL_RS;
        b_sel     = B_SEL_IMM;
        imm       = zimm;
        alu_op    = (opcode == UPARC_OPC_ANDI) ? UPARC_ALUOP_AND :
                    (opcode == UPARC_OPC_ORI)  ? UPARC_ALUOP_OR  : UPARC_ALUOP_XOR;
      end
      UPARC_OPC_LUI: begin
        dst       = rt;
        supported = 1'b1;
        a_sel     = A_SEL_IMM;
        imm       = {instr[15:0], 16'h0000};
      end
      default: supported = 1'b0;
    endcase
  end

  assign rsvd  = !supported;
  assign rd    = supported ? dst : '0;
  assign wr_en = supported && (dst != '0);

endmodule

// File: rtl/uparc_idecode.sv
// Ultiparc instruction decode stage: register reads, optional execute-stage
// forwarding (enabled by defining UPARC_IDECODE_FWD_EN) and a one-entry
// valid/ready ALU command output register.
module uparc_idecode
  import uparc_idecode_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  uparc_idecode_if.slave bus
);

  logic [UPARC_RADDR_WIDTH-1:0] rs, rt, rd;
  logic [UPARC_ALUOP_WIDTH-1:0] alu_op;
  a_sel_e                       a_sel;
  b_sel_e                       b_sel;
  logic [UPARC_REG_WIDTH-1:0]   imm;
  logic                         wr_en, ovf_trap, rsvd;
  logic [UPARC_REG_WIDTH-1:0]   rs_val, rt_val;
  alu_cmd_t                     cmd_d, cmd_q;
  logic                         valid_q;
  logic                         load;

  uparc_idec_logic u_logic (
    .instr    (bus.i_instr),
    .rs       (rs),
    .rt       (rt),
    .alu_op   (alu_op),
    .a_sel    (a_sel),
    .b_sel    (b_sel),
    .imm      (imm),
    .rd       (rd),
    .wr_en    (wr_en),
    .ovf_trap (ovf_trap),
    .rsvd     (rsvd)
  );

  assign bus.rf_raddr_a = rs;
  assign bus.rf_raddr_b = rt;

`ifndef UPARC_IDECODE_FWD_EN
  logic fwd_unused;
  assign fwd_unused = ^{bus.fwd_valid, bus.fwd_reg, bus.fwd_data};
`endif

  // Source register values: forwarded result when enabled, $0 always zero
  always_comb begin
    rs_val = bus.rf_rdata_a;
    rt_val = bus.rf_rdata_b;
`ifdef UPARC_IDECODE_FWD_EN
    if (bus.fwd_valid && (bus.fwd_reg == rs)) rs_val = bus.fwd_data;
    if (bus.fwd_valid && (bus.fwd_reg == rt)) rt_val = bus.fwd_data;
`endif
    if (rs == '0) rs_val = '0;
    if (rt == '0) rt_val = '0;
  end

  // Assemble the next ALU command from the decoder selects
  always_comb begin
    cmd_d          = '0;
    cmd_d.alu_op   = alu_op;
    cmd_d.rd       = rd;
    cmd_d.wr_en    = wr_en;
    cmd_d.ovf_trap = ovf_trap;
    cmd_d.rsvd     = rsvd;
    case (a_sel)
      A_SEL_RS:  cmd_d.a = rs_val;
      A_SEL_RT:  cmd_d.a = rt_val;
      A_SEL_IMM: cmd_d.a = imm;
      default:   cmd_d.a = '0;
    endcase
    case (b_sel)
      B_SEL_RS:  cmd_d.b = rs_val;
      B_SEL_RT:  cmd_d.b = rt_val;
      B_SEL_IMM: cmd_d.b = imm;
      default:   cmd_d.b = '0;
    endcase
  end

  assign bus.i_ready = !valid_q || bus.o_ready;
  assign load        = bus.i_valid && bus.i_ready;

  // Output register: flush beats load, load beats retire, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      cmd_q   <= cmd_d;
    end else if (bus.o_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_alu_op   = cmd_q.alu_op;
  assign bus.o_a        = cmd_q.a;
  assign bus.o_b        = cmd_q.b;
  assign bus.o_rd       = cmd_q.rd;
  assign bus.o_wr_en    = cmd_q.wr_en;
  assign bus.o_ovf_trap = cmd_q.ovf_trap;
  assign bus.o_rsvd     = cmd_q.rsvd;

endmodule
